dmem_handshake_ctrl: RTL and testbench



---
 rtl/dmem_handshake_ctrl.sv | 139 +++++++++++++
 tb/tb_dmem_handshake_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_handshake_ctrl.sv
// Converts single-cycle MEM-stage load/store strobes into a req/ack handshake
// with a multi-cycle data memory, stalling the pipeline while an access is open.
module dmem_handshake_ctrl #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re_mem,
  input  logic              we_mem,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] sdata,
  output logic [DATA_W-1:0] ldata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);
  localparam logic [7:0] WAIT_LAST  = 8'(MAX_WAIT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;

  logic start;
  logic conflict;
  logic ack_hit;
  logic timeout;
  logic wait_miss;
  logic spurious;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Timeout fires in the WAIT cycle that would push the counter to MAX_WAIT,
  // so a silent memory gets exactly MAX_WAIT request cycles.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    conflict  = 1'b0;
    ack_hit   = 1'b0;
    timeout   = 1'b0;
    wait_miss = 1'b0;
    spurious  = 1'b0;
    case (state)
      ST_IDLE: begin
        spurious = mem_ack;
        if (re_mem || we_mem) begin
          start     = 1'b1;
          conflict  = re_mem && we_mem;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          ack_hit   = 1'b1;
          state_nxt = ST_DONE;
        end else if (wait_cnt >= WAIT_LAST) begin
          timeout   = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          wait_miss = 1'b1;
        end
      end
      ST_DONE: begin
        spurious  = mem_ack;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Stall is gated by rst_n so it drops with reset even if a strobe is still high.
  always_comb begin
    stall = 1'b0;
    if (rst_n) begin
      stall = (state == ST_WAIT) || ((state == ST_IDLE) && (re_mem || we_mem));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ldata     <= '0;
      err       <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      if (start) begin
        mem_addr  <= addr;
        mem_wdata <= sdata;
        mem_we    <= we_mem;
        mem_req   <= 1'b1;
        wait_cnt  <= '0;
      end
      if (ack_hit) begin
        mem_req <= 1'b0;
        if (!mem_we) begin
          ldata <= mem_rdata;
        end
      end
      if (timeout) begin
        mem_req <= 1'b0;
        if (!mem_we) begin
          ldata <= '0;
        end
      end
      if ((timeout || wait_miss) && (wait_cnt < WAIT_LIMIT)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (conflict || timeout || spurious) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_handshake_ctrl.sv
// Scoreboard bench for dmem_handshake_ctrl: stimulus pushes per-access
// expectations, a negedge monitor checks request fields and the DONE cycle.
module tb_dmem_handshake_ctrl;

  localparam int MAXW = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        re_mem, we_mem;
  logic [15:0] addr, sdata;
  logic [15:0] ldata;
  logic        stall, mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        err;

  dmem_handshake_ctrl #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .re_mem(re_mem), .we_mem(we_mem),
    .addr(addr), .sdata(sdata), .ldata(ldata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          stalls;
    logic [15:0] ldata;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  logic        m_err = 1'b0;
  logic [15:0] m_ldata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
  task automatic do_op(input bit re, input bit we, input logic [15:0] a,
                       input logic [15:0] d, input int k, input logic [15:0] rd);
    exp_t e;
    bit   to;
    int   nw;
    to = (k == 0) || (k > MAXW);
    nw = to ? MAXW : k;
    if (re && we) m_err = 1'b1;
    if (to) m_err = 1'b1;
    if (!we) m_ldata = to ? 16'h0000 : rd;
    e.we = we; e.addr = a; e.wdata = d; e.stalls = nw + 1;
    e.ldata = m_ldata; e.err = m_err;
    q.push_back(e);
    re_mem = re; we_mem = we; addr = a; sdata = d;
    for (int i = 1; i <= nw; i++) begin
      @(posedge clk); #1;
      if (!to && i == k) begin
        mem_ack = 1'b1; mem_rdata = rd;
      end else begin
        mem_ack = 1'b0; mem_rdata = 16'($urandom);
      end
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    addr = 16'($urandom);
    @(posedge clk); #1;
    re_mem = 1'b0; we_mem = 1'b0;
  endtask

  task automatic idle(input int n, input bit spur);
    if (spur) begin
      mem_ack = 1'b1;
      m_err = 1'b1;
    end
    repeat (n) begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
  endtask

  bit   in_op = 1'b0;
  int   ncyc = 0;
  exp_t me;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_op = 1'b0;
    end else if (stall) begin
      if (!in_op) begin
        in_op = 1'b1;
        ncyc = 1;
        chk("req_in_detect", 32'(mem_req), 32'd0);
      end else begin
        ncyc++;
        if (q.size() == 0) begin
          chk("queue_nonempty_wait", 32'd0, 32'd1);
        end else begin
          chk("req_wait", 32'(mem_req), 32'd1);
          chk("mem_we", 32'(mem_we), 32'(q[0].we));
          chk("mem_addr", 32'(mem_addr), 32'(q[0].addr));
          chk("mem_wdata", 32'(mem_wdata), 32'(q[0].wdata));
        end
      end
    end else if (in_op) begin
      in_op = 1'b0;
      if (q.size() == 0) begin
        chk("queue_nonempty_done", 32'd0, 32'd1);
      end else begin
        me = q.pop_front();
        chk("stall_cycles", 32'(ncyc), 32'(me.stalls));
        chk("ldata_done", 32'(ldata), 32'(me.ldata));
        chk("err_done", 32'(err), 32'(me.err));
        chk("req_done", 32'(mem_req), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; re_mem = 1'b0; we_mem = 1'b0; addr = '0; sdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #3;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ldata", 32'(ldata), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2, 1'b0);

    do_op(1, 0, 16'h0040, 16'h0000, 1, 16'hBEEF);
    idle(1, 1'b0);
    do_op(0, 1, 16'h0012, 16'h1234, 4, 16'h5555);
    idle(2, 1'b0);
    do_op(1, 0, 16'h0100, 16'h0000, 1, 16'hA5A5);
    do_op(0, 1, 16'h0200, 16'h7777, 1, 16'h0000);
    idle(1, 1'b0);
    do_op(1, 0, 16'h0300, 16'h0000, 0, 16'h0000);
    do_op(1, 0, 16'h0302, 16'h0000, 2, 16'hC0DE);
    idle(1, 1'b0);
    do_op(1, 1, 16'h0008, 16'h9999, 1, 16'h0000);
    idle(1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int r;
      bit re, we;
      r = int'($urandom_range(0, 9));
      re = (r == 0) || (r < 5);
      we = (r == 0) || (r >= 5);
      do_op(re, we, 16'($urandom), 16'($urandom), int'($urandom_range(0, 17)), 16'($urandom));
      r = int'($urandom_range(0, 2));
      if (r > 0) idle(r, ($urandom_range(0, 7) == 0));
    end

    re_mem = 1'b1; we_mem = 1'b0; addr = 16'h0444; mem_ack = 1'b0;
    begin
      exp_t dummy;
      dummy.we = 1'b0; dummy.addr = 16'h0444; dummy.wdata = sdata;
      dummy.stalls = 0; dummy.ldata = '0; dummy.err = m_err;
      q.push_back(dummy);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(mem_req), 32'd0);
    chk("async_rst_stall", 32'(stall), 32'd0);
    chk("async_rst_ldata", 32'(ldata), 32'd0);
    chk("async_rst_err", 32'(err), 32'd0);
    q.delete();
    re_mem = 1'b0; m_err = 1'b0; m_ldata = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_err", 32'(err), 32'd0);
    idle(1, 1'b1);
    chk("spurious_ack_err", 32'(err), 32'd1);
    do_op(1, 0, 16'h0050, 16'h0000, 2, 16'h1357);
    idle(3, 1'b0);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
